// File: rtl/ahb_slv_dec_mux_pkg.sv
// Shared AHB-Lite constants for the slave decoder / response multiplexer.
package ahb_slv_dec_mux_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam int NUM_SLV = 4;
    localparam int S0      = 0;
    localparam int S1      = 1;
    localparam int S2      = 2;
    localparam int S3      = 3;

endpackage

// File: rtl/ahb_err_log.sv
// Debug log of ERROR responses and data-phase stalls; observation only, never alters the bus.
module ahb_err_log
    import ahb_slv_dec_mux_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int TO_CYC = 256
) (
    input  logic              pll_core_cpuclk,
    input  logic              pad_cpu_rst_b,
    input  logic              err_clr,
    input  logic              dsel_any,
    input  logic              hready_m,
    input  logic [1:0]        hresp_m,
    input  logic [ADDR_W-1:0] daddr,
    output logic              err_vld,
    output logic [ADDR_W-1:0] err_addr,
    output logic [7:0]        err_cnt,
    output logic              to_flag
);

    localparam int WC_W = $clog2(TO_CYC) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TO_CYC - 1);

    logic [WC_W-1:0]   wait_cnt_r;
    logic              err_vld_r;
    logic [ADDR_W-1:0] err_addr_r;
    logic [7:0]        err_cnt_r;
    logic              to_flag_r;
    logic              err_evt_s;
    logic              to_evt_s;

    // ERROR is logged on its second (hready=1) beat so a two-cycle response counts once
    assign err_evt_s = dsel_any & hready_m & (hresp_m == HRESP_ERROR);
    assign to_evt_s  = dsel_any & ~hready_m & (wait_cnt_r == WC_LAST);

    // Stall counter; parks at its limit so a very long stall cannot wrap
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            wait_cnt_r <= '0;
        end else if (hready_m) begin
            wait_cnt_r <= '0;
        end else if (dsel_any && (wait_cnt_r != WC_LAST)) begin
            wait_cnt_r <= wait_cnt_r + WC_W'(1);
        end
    end

    // Sticky error/timeout log; a clear in the same cycle as an event drops the event
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            err_vld_r  <= 1'b0;
            err_addr_r <= '0;
            err_cnt_r  <= 8'h00;
            to_flag_r  <= 1'b0;
        end else if (err_clr) begin
            err_vld_r  <= 1'b0;
            err_addr_r <= '0;
            err_cnt_r  <= 8'h00;
            to_flag_r  <= 1'b0;
        end else begin
            if (err_evt_s) begin
                err_vld_r <= 1'b1;
                if (!err_vld_r) begin
                    err_addr_r <= daddr;
                end
                if (err_cnt_r != 8'hFF) begin
                    err_cnt_r <= err_cnt_r + 8'd1;
                end
            end
            if (to_evt_s) begin
                to_flag_r <= 1'b1;
            end
        end
    end

    assign err_vld  = err_vld_r;
    assign err_addr = err_addr_r;
    assign err_cnt  = err_cnt_r;
    assign to_flag  = to_flag_r;

endmodule

// File: rtl/ahb_slv_dec_mux.sv
// Single-master AHB-Lite address decoder and response mux for slaves s0..s3 (s3 = default slave).
module ahb_slv_dec_mux
    import ahb_slv_dec_mux_pkg::*;
#(
    parameter int              ADDR_W  = 32,
    parameter logic [31:0]     S0_BASE = 32'h0000_0000,
    parameter logic [31:0]     S0_MASK = 32'hFFF0_0000,
    parameter logic [31:0]     S1_BASE = 32'h1000_0000,
    parameter logic [31:0]     S1_MASK = 32'hFFFF_0000,
    parameter logic [31:0]     S2_BASE = 32'h4000_0000,
    parameter logic [31:0]     S2_MASK = 32'hF000_0000,
    parameter int              TO_CYC  = 256
) (
    input  logic              pll_core_cpuclk,
    input  logic              pad_cpu_rst_b,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic              hmastlock,
    input  logic [127:0]      hwdata,
    output logic [127:0]      hrdata,
    output logic              hready,
    output logic [1:0]        hresp,
    output logic              hsel_s0,
    output logic              hsel_s1,
    output logic              hsel_s2,
    output logic              hsel_s3,
    input  logic [127:0]      hrdata_s0,
    input  logic              hready_s0,
    input  logic [1:0]        hresp_s0,
    input  logic [127:0]      hrdata_s1,
    input  logic              hready_s1,
    input  logic [1:0]        hresp_s1,
    input  logic [127:0]      hrdata_s2,
    input  logic              hready_s2,
    input  logic [1:0]        hresp_s2,
    input  logic [127:0]      hrdata_s3,
    input  logic              hready_s3,
    input  logic [1:0]        hresp_s3,
    input  logic              err_clr,
    output logic              err_vld,
    output logic [ADDR_W-1:0] err_addr,
    output logic [7:0]        err_cnt,
    output logic              to_flag
);

    logic [NUM_SLV-1:0] match_s;
    logic [NUM_SLV-1:0] hsel_vec_s;
    logic [NUM_SLV-1:0] dsel_r;
    logic [ADDR_W-1:0]  daddr_r;
    logic               xfer_s;
    logic [127:0]       hrdata_s;
    logic               hready_s;
    logic [1:0]         hresp_s;
    logic               unused_fwd_s;

    // Controls and write data go straight to the slaves; the decoder has no use for them
    assign unused_fwd_s = ^{hwrite, hsize, hburst, hprot, hmastlock, hwdata};

    // Priority address decode s0 > s1 > s2, anything else lands on s3
    always_comb begin
        match_s = '0;
        if ((haddr & ADDR_W'(S0_MASK)) == ADDR_W'(S0_BASE)) begin
            match_s[S0] = 1'b1;
        end else if ((haddr & ADDR_W'(S1_MASK)) == ADDR_W'(S1_BASE)) begin
            match_s[S1] = 1'b1;
        end else if ((haddr & ADDR_W'(S2_MASK)) == ADDR_W'(S2_BASE)) begin
            match_s[S2] = 1'b1;
        end else begin
            match_s[S3] = 1'b1;
        end
    end

    // Gating with hready keeps s3's own wait state from re-selecting it forever
    assign xfer_s     = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign hsel_vec_s = match_s & {NUM_SLV{xfer_s & hready_s}};

    assign hsel_s0 = hsel_vec_s[S0];
    assign hsel_s1 = hsel_vec_s[S1];
    assign hsel_s2 = hsel_vec_s[S2];
    assign hsel_s3 = hsel_vec_s[S3];

    // Data-phase owner and address advance only when the bus completes a beat
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            dsel_r  <= '0;
            daddr_r <= '0;
        end else if (hready_s) begin
            dsel_r  <= hsel_vec_s;
            daddr_r <= haddr;
        end
    end

    // Response mux; an idle data phase (or an illegal multi-hot owner) reads as OKAY/ready
    always_comb begin
        hrdata_s = '0;
        hready_s = 1'b1;
        hresp_s  = HRESP_OKAY;
        case (dsel_r)
            4'b0001: begin
                hrdata_s = hrdata_s0;
                hready_s = hready_s0;
                hresp_s  = hresp_s0;
            end
            4'b0010: begin
                hrdata_s = hrdata_s1;
                hready_s = hready_s1;
                hresp_s  = hresp_s1;
            end
            4'b0100: begin
                hrdata_s = hrdata_s2;
                hready_s = hready_s2;
                hresp_s  = hresp_s2;
            end
            4'b1000: begin
                hrdata_s = hrdata_s3;
                hready_s = hready_s3;
                hresp_s  = hresp_s3;
            end
            default: begin
                hrdata_s = '0;
                hready_s = 1'b1;
                hresp_s  = HRESP_OKAY;
            end
        endcase
    end

    assign hrdata = hrdata_s;
    assign hready = hready_s;
    assign hresp  = hresp_s;

    ahb_err_log #(
        .ADDR_W (ADDR_W),
        .TO_CYC (TO_CYC)
    ) u_err_log (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .err_clr         (err_clr),
        .dsel_any        (|dsel_r),
        .hready_m        (hready_s),
        .hresp_m         (hresp_s),
        .daddr           (daddr_r),
        .err_vld         (err_vld),
        .err_addr        (err_addr),
        .err_cnt         (err_cnt),
        .to_flag         (to_flag)
    );

endmodule
